// File: rtl/tl_mem_master.sv
// TileLink-UL initiator for one L2 memory port. It issues single-beat Get/Put requests on channel A.
// It tracks outstanding source IDs and returns D responses, which may arrive in any order, with protocol error checking.
module tl_mem_master #(
  parameter int OP_BITS      = 3,
  parameter int SIZE_BITS    = 3,
  parameter int SOURCE_BITS  = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int DATA_BITS    = 64,
  parameter int MASK_BITS    = 8,
  parameter int NUM_SRC      = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  // Handshakes (req, A, D, rsp): a beat transfers on a rising edge where valid && ready;
  // a producer holding valid keeps its payload unchanged until that edge.
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESS_BITS-1:0] req_address,
  input  logic [DATA_BITS-1:0]    req_data,
  input  logic [MASK_BITS-1:0]    req_mask,
  output logic                    out_a_valid_o,
  input  logic                    out_a_ready_i,
  output logic [OP_BITS-1:0]      out_a_opcode_o,
  output logic [SIZE_BITS-1:0]    out_a_size_o,
  output logic [SOURCE_BITS-1:0]  out_a_source_o,
  output logic [ADDRESS_BITS-1:0] out_a_address_o,
  output logic [MASK_BITS-1:0]    out_a_mask_o,
  output logic [DATA_BITS-1:0]    out_a_data_o,
  output logic [2:0]              out_a_param_o,
  input  logic                    out_d_valid_i,
  output logic                    out_d_ready_o,
  input  logic [OP_BITS-1:0]      out_d_opcode_i,
  input  logic [SIZE_BITS-1:0]    out_d_size_i,
  input  logic [SOURCE_BITS-1:0]  out_d_source_i,
  input  logic [DATA_BITS-1:0]    out_d_data_i,
  input  logic [2:0]              out_d_param_i,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [SOURCE_BITS-1:0]  rsp_source,
  output logic [DATA_BITS-1:0]    rsp_data,
  output logic                    rsp_err,
  output logic [SOURCE_BITS:0]    outstanding,
  output logic                    idle,
  output logic                    a_state_o
);

  typedef enum logic {A_IDLE = 1'b0, A_SEND = 1'b1} a_state_e;

  localparam logic [SIZE_BITS-1:0] BEAT_SIZE   = SIZE_BITS'($clog2(DATA_BITS / 8));
  localparam logic [OP_BITS-1:0]   OP_GET      = OP_BITS'(4);
  localparam logic [OP_BITS-1:0]   OP_PUT_FULL = OP_BITS'(0);
  localparam logic [OP_BITS-1:0]   OP_PUT_PART = OP_BITS'(1);
  localparam logic [OP_BITS-1:0]   OP_ACK      = OP_BITS'(0);
  localparam logic [OP_BITS-1:0]   OP_ACK_DATA = OP_BITS'(1);

  a_state_e                state_q;
  logic [OP_BITS-1:0]      a_opcode_q;
  logic [SIZE_BITS-1:0]    a_size_q;
  logic [SOURCE_BITS-1:0]  a_source_q;
  logic [ADDRESS_BITS-1:0] a_address_q;
  logic [MASK_BITS-1:0]    a_mask_q;
  logic [DATA_BITS-1:0]    a_data_q;

  logic [NUM_SRC-1:0]      busy_q, busy_d, is_write_q, is_write_d, alloc_oh, free_oh;
  logic [SOURCE_BITS-1:0]  alloc_src;
  logic                    has_free, accept, a_fire, d_fire, src_ok, src_wr, d_err;
  logic                    rsp_valid_q, rsp_write_q, rsp_err_q;
  logic [SOURCE_BITS-1:0]  rsp_source_q;
  logic [DATA_BITS-1:0]    rsp_data_q;
  logic [SOURCE_BITS:0]    busy_cnt;
  logic                    unused_d_param;

  assign unused_d_param = ^out_d_param_i;

  // Allocation looks only at the registered bitmap, so a source freed this cycle is not reused until next cycle.
  always_comb begin
    has_free  = 1'b0;
    alloc_src = '0;
    alloc_oh  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!busy_q[i] && !has_free) begin
        has_free    = 1'b1;
        alloc_src   = SOURCE_BITS'(i);
        alloc_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    src_ok  = 1'b0;
    src_wr  = 1'b0;
    free_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (out_d_source_i == SOURCE_BITS'(i) && busy_q[i]) begin
        src_ok     = 1'b1;
        src_wr     = is_write_q[i];
        free_oh[i] = 1'b1;
      end
    end
    d_err = !src_ok || (out_d_opcode_i != (src_wr ? OP_ACK : OP_ACK_DATA)) ||
            (out_d_size_i != BEAT_SIZE);
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) busy_cnt = busy_cnt + {{SOURCE_BITS{1'b0}}, busy_q[i]};
  end

  assign req_ready     = has_free && (state_q == A_IDLE || out_a_ready_i);
  assign accept        = req_valid && req_ready;
  assign a_fire        = out_a_valid_o && out_a_ready_i;
  assign out_d_ready_o = !rsp_valid_q || rsp_ready;
  assign d_fire        = out_d_valid_i && out_d_ready_o;

  assign busy_d     = (busy_q & ~(d_fire ? free_oh : '0)) | (accept ? alloc_oh : '0);
  assign is_write_d = accept ? ((is_write_q & ~alloc_oh) | (req_write ? alloc_oh : '0)) : is_write_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= A_IDLE;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
    end else if (accept) begin
      state_q     <= A_SEND;
      a_opcode_q  <= !req_write ? OP_GET : (&req_mask ? OP_PUT_FULL : OP_PUT_PART);
      a_size_q    <= BEAT_SIZE;
      a_source_q  <= alloc_src;
      a_address_q <= req_address;
      a_mask_q    <= req_write ? req_mask : '1;
      a_data_q    <= req_write ? req_data : '0;
    end else if (a_fire) begin
      state_q <= A_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q       <= '0;
      is_write_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_source_q <= '0;
      rsp_data_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      is_write_q <= is_write_d;
      if (d_fire) begin
        rsp_valid_q  <= 1'b1;
        rsp_write_q  <= src_wr;
        rsp_err_q    <= d_err;
        rsp_source_q <= out_d_source_i;
        rsp_data_q   <= src_wr ? '0 : out_d_data_i;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign out_a_valid_o   = (state_q == A_SEND);
  assign out_a_opcode_o  = a_opcode_q;
  assign out_a_size_o    = a_size_q;
  assign out_a_source_o  = a_source_q;
  assign out_a_address_o = a_address_q;
  assign out_a_mask_o    = a_mask_q;
  assign out_a_data_o    = a_data_q;
  assign out_a_param_o   = 3'd0;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_write       = rsp_write_q;
  assign rsp_source      = rsp_source_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_err         = rsp_err_q;
  assign outstanding     = busy_cnt;
  assign idle            = !out_a_valid_o && (busy_q == '0) && !rsp_valid_q;
  assign a_state_o       = state_q;

endmodule

// File: tb/tb_tl_mem_master.sv
// Bench for tl_mem_master: directed and random requests/responses checked against a source-bitmap
// reference model, with negedge monitors for the A beats, the D-ready rule and the held responses.
module tb_tl_mem_master;
  localparam int NUM_SRC = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_address;
  logic [63:0] req_data;
  logic [7:0]  req_mask;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_size, a_param;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_size, d_param;
  logic [3:0]  d_source;
  logic [63:0] d_data;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [3:0]  rsp_source;
  logic [63:0] rsp_data;
  logic [4:0]  outstanding;
  logic        idle, a_state;

  int checks = 0;
  int errors = 0;
  int last_src;
  logic [127:0] a_exp_q[$];
  logic [127:0] exp_q[$];
  bit busy_m[NUM_SRC];
  bit wr_m[NUM_SRC];

  always #5 clk = ~clk;

  tl_mem_master dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data), .req_mask(req_mask),
    .out_a_valid_o(a_valid), .out_a_ready_i(a_ready), .out_a_opcode_o(a_opcode),
    .out_a_size_o(a_size), .out_a_source_o(a_source), .out_a_address_o(a_address),
    .out_a_mask_o(a_mask), .out_a_data_o(a_data), .out_a_param_o(a_param),
    .out_d_valid_i(d_valid), .out_d_ready_o(d_ready), .out_d_opcode_i(d_opcode),
    .out_d_size_i(d_size), .out_d_source_i(d_source), .out_d_data_i(d_data),
    .out_d_param_i(d_param),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_source(rsp_source), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .outstanding(outstanding), .idle(idle), .a_state_o(a_state)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NUM_SRC; i++) c += int'(busy_m[i]);
    return c;
  endfunction

  function automatic int model_alloc();
    for (int i = 0; i < NUM_SRC; i++) if (!busy_m[i]) return i;
    return -1;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Request one beat; optionally stall channel A for 'hold' cycles right after acceptance.
  task automatic issue(input logic w, input logic [31:0] addr, input logic [63:0] data,
                       input logic [7:0] mask, input int hold);
    int n = 0;
    logic [2:0] op;
    req_valid = 1'b1; req_write = w; req_address = addr; req_data = data; req_mask = mask;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("req_accept_wait", req_ready, 1'b1);
    if (req_ready === 1'b1) begin
      last_src = model_alloc();
      op = w ? ((mask == 8'hFF) ? 3'd0 : 3'd1) : 3'd4;
      a_exp_q.push_back({op, 4'(last_src), addr, w ? mask : 8'hFF, w ? data : 64'd0});
      @(posedge clk);
      busy_m[last_src] = 1'b1;
      wr_m[last_src] = w;
      #1;
    end
    req_valid = 1'b0;
    if (hold > 0) begin
      a_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        chk("req_ready_a_stall", req_ready, 1'b0);
        tick();
      end
      a_ready = 1'b1;
    end
  endtask

  task automatic respond(input logic [3:0] src, input logic [2:0] op, input logic [63:0] data,
                         input logic [2:0] size);
    int n = 0;
    int idx;
    bit ok, ew, err;
    d_valid = 1'b1; d_source = src; d_opcode = op; d_data = data; d_size = size;
    d_param = 3'($urandom_range(0, 7));
    @(negedge clk);
    while (d_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("d_accept_wait", d_ready, 1'b1);
    if (d_ready === 1'b1) begin
      idx = int'(src);
      ok  = (idx < NUM_SRC) ? busy_m[idx] : 1'b0;
      ew  = ok && wr_m[idx];
      err = !ok || (op != (ew ? 3'd0 : 3'd1)) || (size != 3'd3);
      exp_q.push_back({ew, src, err, ew ? 64'd0 : data});
      @(posedge clk);
      if (ok) busy_m[idx] = 1'b0;
      #1;
    end
    d_valid = 1'b0;
  endtask

  logic [127:0] prev_a, prev_rsp;
  bit prev_a_hold, prev_rsp_hold;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_a_hold = 1'b0;
      prev_rsp_hold = 1'b0;
    end else begin
      chk("d_ready_rule", d_ready, !rsp_valid || rsp_ready);
      if (prev_a_hold)
        chk("a_stable", {a_valid, a_size, a_param, a_opcode, a_source, a_address, a_mask, a_data}, prev_a);
      if (a_valid && a_ready) begin
        chk("a_beat_expected", a_exp_q.size() != 0, 1'b1);
        if (a_exp_q.size() != 0) begin
          chk("a_beat", {a_opcode, a_source, a_address, a_mask, a_data}, a_exp_q.pop_front());
          chk("a_size", a_size, 3'd3);
          chk("a_param", a_param, 3'd0);
        end
      end
      prev_a_hold = a_valid && !a_ready;
      prev_a = {a_valid, a_size, a_param, a_opcode, a_source, a_address, a_mask, a_data};
      if (prev_rsp_hold)
        chk("rsp_stable", {rsp_valid, rsp_write, rsp_source, rsp_err, rsp_data}, prev_rsp);
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0)
          chk("rsp", {rsp_write, rsp_source, rsp_err, rsp_data}, exp_q.pop_front());
      end
      prev_rsp_hold = rsp_valid && !rsp_ready;
      prev_rsp = {rsp_valid, rsp_write, rsp_source, rsp_err, rsp_data};
    end
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || idle !== 1'b1) && n < 100) begin tick(); n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, time %0t", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] m;
    logic [2:0] op;
    int list[$];
    int s;
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0; req_mask = '0;
    a_ready = 1'b1; d_valid = 1'b0; d_opcode = '0; d_size = '0; d_source = '0; d_data = '0;
    d_param = '0; rsp_ready = 1'b1;
    #1;
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_a_payload", {a_opcode, a_size, a_source, a_address, a_mask, a_data}, 0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_source, rsp_err, rsp_data}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_d_ready", d_ready, 1'b1);
    chk("rst_a_state", a_state, 1'b0);
    tick(3);
    rstn = 1'b1;
    tick();
    chk("req_ready_after_rst", req_ready, 1'b1);

    // Single read, then two writes with full and partial masks.
    issue(1'b0, 32'h9000_0000, 64'($urandom), 8'h3C, 0);
    respond(4'(last_src), 3'd1, 64'h1122_3344_5566_7788, 3'd3);
    tick(2);
    chk("read_outstanding", outstanding, 0);
    chk("read_idle", idle, 1'b1);
    issue(1'b1, 32'h9000_1000, 64'hA5A5_0000_1234_5678, 8'hFF, 0);
    s = last_src;
    issue(1'b1, 32'h9000_1000, 64'h0BAD_F00D_CAFE_BEEF, 8'h0F, 0);
    chk("two_writes_outstanding", outstanding, 2);
    respond(4'(s), 3'd0, 64'($urandom), 3'd3);
    respond(4'(last_src), 3'd0, 64'($urandom), 3'd3);
    drain();

    // Channel A stalled for 5 cycles; the monitor flags any payload change or a duplicate beat.
    issue(1'b1, 32'h9000_1008, 64'h0123_4567_89AB_CDEF, 8'hF0, 5);
    tick(3);
    respond(4'(last_src), 3'd0, 64'd0, 3'd3);
    drain();

    // Exhaust all sources, check the stall, then reuse a freed source.
    for (int i = 0; i < NUM_SRC; i++) issue(1'b0, 32'h9000_2000 + 32'(i * 8), 64'd0, 8'h00, 0);
    tick();
    chk("full_outstanding", outstanding, NUM_SRC);
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h9000_3000;
    repeat (3) begin @(negedge clk); chk("full_req_ready", req_ready, 1'b0); end
    tick();
    req_valid = 1'b0;
    respond(4'd2, 3'd1, 64'hDEAD_0002_0002_0002, 3'd3);
    issue(1'b0, 32'h9000_3000, 64'd0, 8'h00, 0);
    chk("realloc_outstanding", outstanding, NUM_SRC);

    // Out-of-order returns while the consumer toggles rsp_ready.
    fork
      begin
        repeat (30) begin @(posedge clk); #1; rsp_ready = ~rsp_ready; end
        rsp_ready = 1'b1;
      end
      begin
        respond(4'd3, 3'd1, 64'h3333_3333_3333_3333, 3'd3);
        respond(4'd0, 3'd1, 64'h0000_0000_0000_0A0A, 3'd3);
        respond(4'd1, 3'd1, 64'h1111_1111_1111_1111, 3'd3);
        respond(4'd2, 3'd1, 64'h2222_2222_2222_2222, 3'd3);
      end
    join
    drain();
    chk("ooo_outstanding", outstanding, 0);

    // Error responses: unallocated/out-of-range source, wrong opcode, wrong size.
    respond(4'd3, 3'd1, 64'h5555_AAAA_5555_AAAA, 3'd3);
    chk("err_unalloc_outstanding", outstanding, 0);
    respond(4'd9, 3'd1, 64'h9999_0000_9999_0000, 3'd3);
    issue(1'b0, 32'h9000_4000, 64'd0, 8'h00, 0);
    respond(4'(last_src), 3'd0, 64'h4444_4444_0000_0000, 3'd3);
    issue(1'b0, 32'h9000_4008, 64'd0, 8'h00, 0);
    respond(4'(last_src), 3'd1, 64'h4444_4444_1111_1111, 3'd2);
    issue(1'b1, 32'h9000_4010, 64'h77, 8'hFF, 0);
    respond(4'(last_src), 3'd1, 64'h4444_4444_2222_2222, 3'd3);
    drain();
    chk("err_outstanding", outstanding, 0);

    // Reset while a response is held and an A beat is pending.
    issue(1'b0, 32'h9000_5000, 64'd0, 8'h00, 0);
    rsp_ready = 1'b0;
    respond(4'(last_src), 3'd1, 64'h5050_5050_5050_5050, 3'd3);
    a_ready = 1'b0;
    issue(1'b1, 32'h9000_5008, 64'h6060, 8'h01, 0);
    s = last_src;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_a_valid", a_valid, 1'b0);
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_idle", idle, 1'b1);
    a_exp_q.delete();
    exp_q.delete();
    for (int i = 0; i < NUM_SRC; i++) begin busy_m[i] = 1'b0; wr_m[i] = 1'b0; end
    tick(2);
    rstn = 1'b1;
    a_ready = 1'b1;
    rsp_ready = 1'b1;
    tick();
    respond(4'(s), 3'd0, 64'hBEEF, 3'd3);
    drain();

    // Random traffic against the bitmap model.
    for (int it = 0; it < 120; it++) begin
      if (model_count() < NUM_SRC && (model_count() == 0 || $urandom_range(0, 1) == 1)) begin
        m = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        issue(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFF8, {$urandom, $urandom}, m,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end else begin
        list.delete();
        for (int i = 0; i < NUM_SRC; i++) if (busy_m[i]) list.push_back(i);
        s = list[$urandom_range(0, list.size() - 1)];
        op = wr_m[s] ? 3'd0 : 3'd1;
        if ($urandom_range(0, 9) == 0) op = op ^ 3'd1;
        respond(4'(s), op, {$urandom, $urandom}, ($urandom_range(0, 15) == 0) ? 3'd2 : 3'd3);
      end
      chk("rand_outstanding", outstanding, model_count());
    end
    while (model_count() != 0) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (busy_m[i]) respond(4'(i), wr_m[i] ? 3'd0 : 3'd1, {$urandom, $urandom}, 3'd3);
    end
    drain();
    chk("final_idle", idle, 1'b1);
    chk("final_outstanding", outstanding, 0);
    chk("final_a_queue", a_exp_q.size(), 0);
    chk("final_rsp_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_mem_master.md
Name: tl_mem_master

Overview:
- Synthesizable TileLink-UL A-channel initiator and D-channel receiver, one per L2 cache memory port. It is the counterpart of the bench memory responder.
- Accepts one-beat line-segment read/write requests from the L2 miss/writeback logic and issues Get/PutFullData/PutPartialData on channel A.
- Tracks outstanding transactions by source ID and returns D-channel responses, possibly out of order, to the requester with error checking.

Parameters:
- OP_BITS, 3, A/D opcode width
- SIZE_BITS, 3, size field width
- SOURCE_BITS, 4, source field width; must satisfy 2^SOURCE_BITS >= NUM_SRC
- ADDRESS_BITS, 32, byte address width
- DATA_BITS, 64, beat data width
- MASK_BITS, 8, byte mask width (DATA_BITS/8)
- NUM_SRC, 4, maximum outstanding transactions (source IDs 0..NUM_SRC-1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_address  in  ADDRESS_BITS  byte address, DATA_BITS/8-aligned
- req_data  in  DATA_BITS  write data
- req_mask  in  MASK_BITS  write byte enables; ignored for reads
- out_a_valid_o  out  1  A valid
- out_a_ready_i  in  1  A ready
- out_a_opcode_o  out  OP_BITS  4=Get, 0=PutFullData, 1=PutPartialData
- out_a_size_o  out  SIZE_BITS  log2(DATA_BITS/8)
- out_a_source_o  out  SOURCE_BITS  allocated source ID
- out_a_address_o  out  ADDRESS_BITS  address
- out_a_mask_o  out  MASK_BITS  all ones for Get, else req_mask
- out_a_data_o  out  DATA_BITS  write data; 0 for Get
- out_a_param_o  out  3  always 0
- out_d_valid_i  in  1  D valid
- out_d_ready_o  out  1  D ready
- out_d_opcode_i  in  OP_BITS  1=AccessAckData, 0=AccessAck
- out_d_size_i  in  SIZE_BITS  ignored except for error check
- out_d_source_i  in  SOURCE_BITS  responding source
- out_d_data_i  in  DATA_BITS  read data
- out_d_param_i  in  3  ignored
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_source  out  SOURCE_BITS  source of response
- rsp_data  out  DATA_BITS  read data (0 for write acks)
- rsp_err  out  1  protocol error flag
- outstanding  out  SOURCE_BITS+1  number of allocated sources
- idle  out  1  no A pending, no outstanding, no rsp held

Behaviour:
- Reset (async, rstn=0): out_a_valid_o=0, all A payload=0, rsp_valid=0, rsp payload=0, free bitmap all free, outstanding=0, idle=1. out_d_ready_o=1 after reset.
- A-slot FSM:
  - IDLE -> SEND on request accept; SEND -> IDLE on A fire without a new accept; SEND -> SEND on A fire with a same-cycle accept.
  - req_ready = free source exists AND (slot IDLE OR out_a_ready_i=1). This is a combinational path from out_a_ready_i.
- On accept, register the A payload (1-cycle latency req->A):
  - source = lowest-index free source in the current bitmap, marked busy.
  - per-source is_write bit stored.
  - opcode = req_write ? (req_mask all ones ? 0 : 1) : 4.
  - size = log2(DATA_BITS/8); param = 0.
- A stability: while out_a_valid_o=1 and out_a_ready_i=0, every A output holds stable (TileLink rule).
- D acceptance:
  - out_d_ready_o = !rsp_valid | rsp_ready.
  - On D fire, register the response into rsp_* (1-cycle latency), set rsp_valid, and free the source bit.
  - Held rsp_* is stable until rsp_ready.
- rsp_err=1 on any of the following:
  - source >= NUM_SRC or source not busy (bitmap left unchanged);
  - opcode mismatch: read expects 1, write expects 0;
  - out_d_size_i differs from the issued size.
- A freed source becomes allocatable the cycle after D fire. An alloc in the same cycle as a free uses the pre-free bitmap; no bypass.
- outstanding = popcount of busy bits. Simultaneous alloc+free leaves it unchanged; max value NUM_SRC.
- Source exhaustion: req_ready=0 while all NUM_SRC busy; the A slot may still drain.
- Responses may arrive in any order; no ordering is imposed.
- Reset mid-operation discards the pending A beat, the held response and all allocations immediately. A D beat arriving after reset for a pre-reset source reports rsp_err=1.

Test Plan:
- Read 0x90000000 -> next cycle A: opcode 4, source 0, mask 0xFF, size 3, data 0. Responder returns opcode 1, data 0x1122334455667788 -> rsp_valid, rsp_write=0, rsp_data=0x1122334455667788, rsp_err=0, outstanding back to 0, idle=1.
- Writes with mask 0xFF and 0x0F to 0x90001000 -> A opcodes 0 then 1, sources 0 then 1. AccessAck for each -> rsp_write=1, rsp_data=0.
- Hold out_a_ready_i=0 for 5 cycles after a write is issued -> all A fields constant, req_ready=0. Release -> A fires once, no duplicate beat.
- With NUM_SRC=4, issue 4 reads and hold D idle -> sources 0,1,2,3 issued, outstanding=4, 5th request stalled. Return source 2 -> next accept gets source 2.
- Return D out of order (3,0,1) with rsp_ready toggled 1/0 -> three responses in D order, none lost, out_d_ready_o=0 while a response is held and rsp_ready=0.
- Responses with an unallocated source 3, or opcode 0 to a Get -> rsp_err=1 (bitmap unchanged for the unallocated case).
- Reset asserted while an A beat is pending -> out_a_valid_o=0 immediately, outstanding=0.
